// File: rtl/mod7_counter.sv
// Divide-by-7 counter for the frac-N PLL feedback divider: count taps, terminal-count
// flag, 3/7-duty MSB clock and a 50%-duty clock built from a falling-edge half-cycle flop.
module mod7_counter #(
  parameter logic [2:0] INIT = 3'd0
) (
  input  logic clk,
  input  logic rst,
  output logic bit1,
  output logic bit2,
  output logic bit3,
  output logic bit4,
  output logic out
);

  logic [2:0] count_q, count_d;
  logic       neg_q;

  // 6 wraps to 0; the unreachable 7 (upset) also recovers to 0 on the next edge.
  always_comb begin
    count_d = count_q + 3'd1;
    if (count_q >= 3'd6) begin
      count_d = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= INIT;
    end else begin
      count_q <= count_d;
    end
  end

  // Delays the MSB by half a cycle so the OR below stretches high time to 3.5 cycles.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= count_q[2];
    end
  end

  assign bit1 = count_q[0];
  assign bit2 = count_q[1];
  assign out  = count_q[2];
  assign bit3 = (count_q == 3'd6);
  assign bit4 = count_q[2] | neg_q;

endmodule

// File: tb/tb_mod7_counter.sv
// Bench for mod7_counter: INIT=0 and INIT=3 instances against an arithmetic count model,
// edge-time measurements of the divided clocks, and randomized asynchronous resets.
`timescale 1ns/1ps
module tb_mod7_counter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_bit1, a_bit2, a_bit3, a_bit4, a_out;
  logic b_bit1, b_bit2, b_bit3, b_bit4, b_out;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Model: integer count per instance, and the value of the MSB seen at the last falling edge.
  int  m0 = 0;
  int  m3 = 3;
  bit  n0 = 1'b0;
  bit  n3 = 1'b0;

  realtime out_rise[$], out_fall[$], b4_rise[$], b4_fall[$], b3_rise[$], b3_fall[$];

  mod7_counter #(.INIT(3'd0)) dut0 (
    .clk(clk), .rst(rst), .bit1(a_bit1), .bit2(a_bit2), .bit3(a_bit3), .bit4(a_bit4), .out(a_out)
  );

  mod7_counter #(.INIT(3'd3)) dut3 (
    .clk(clk), .rst(rst), .bit1(b_bit1), .bit2(b_bit2), .bit3(b_bit3), .bit4(b_bit4), .out(b_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m0 = 0;
      m3 = 3;
    end else begin
      m0 = (m0 + 1) % 7;
      m3 = (m3 + 1) % 7;
    end
  end

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      n0 = 1'b0;
      n3 = 1'b0;
    end else begin
      n0 = (m0 >= 4);
      n3 = (m3 >= 4);
    end
  end

  always @(posedge a_out) if (rst) out_rise.push_back($realtime);
  always @(negedge a_out) if (rst) out_fall.push_back($realtime);
  always @(posedge a_bit4) if (rst) b4_rise.push_back($realtime);
  always @(negedge a_bit4) if (rst) b4_fall.push_back($realtime);
  always @(posedge a_bit3) if (rst) b3_rise.push_back($realtime);
  always @(negedge a_bit3) if (rst) b3_fall.push_back($realtime);

  task automatic chk(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %b want %b", name, $time, act, exp);
    end
  endtask

  task automatic chk_t(input string name, input realtime act, input realtime exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0.1f ns want %0.1f ns", name, act, exp);
    end
  endtask

  task automatic chk_model();
    chk("i0.bit1", a_bit1, 1'(m0 % 2));
    chk("i0.bit2", a_bit2, 1'((m0 / 2) % 2));
    chk("i0.out",  a_out,  m0 >= 4);
    chk("i0.bit3", a_bit3, m0 == 6);
    chk("i0.bit4", a_bit4, (m0 >= 4) || n0);
    chk("i3.bit1", b_bit1, 1'(m3 % 2));
    chk("i3.bit2", b_bit2, 1'((m3 / 2) % 2));
    chk("i3.out",  b_out,  m3 >= 4);
    chk("i3.bit3", b_bit3, m3 == 6);
    chk("i3.bit4", b_bit4, (m3 >= 4) || n3);
  endtask

  // Outputs the instant after reset asserts: INIT=0 all low, INIT=3 shows count 3.
  task automatic chk_reset_literal(input string tag);
    chk({tag, ".i0.bit1"}, a_bit1, 1'b0);
    chk({tag, ".i0.bit2"}, a_bit2, 1'b0);
    chk({tag, ".i0.bit3"}, a_bit3, 1'b0);
    chk({tag, ".i0.bit4"}, a_bit4, 1'b0);
    chk({tag, ".i0.out"},  a_out,  1'b0);
    chk({tag, ".i3.bit1"}, b_bit1, 1'b1);
    chk({tag, ".i3.bit2"}, b_bit2, 1'b1);
    chk({tag, ".i3.bit3"}, b_bit3, 1'b0);
    chk({tag, ".i3.bit4"}, b_bit4, 1'b0);
    chk({tag, ".i3.out"},  b_out,  1'b0);
  endtask

  always @(clk) begin
    #1;
    if (chk_en) chk_model();
  end

  initial begin
    bit found;
    #1 rst = 1'b0;
    #1 chk_en = 1'b1;
    chk_reset_literal("reset");
    #18 rst = 1'b1;  // release at 20 ns, between edges

    // First edge after release: no extra latency.
    @(posedge clk);
    #1;
    chk("first_edge.i0.count1", a_bit1 & ~a_bit2 & ~a_out, 1'b1);
    chk("first_edge.i3.out", b_out, 1'b1);
    chk("first_edge.i3.bit4", b_bit4, 1'b1);
    chk("first_edge.i3.bit1", b_bit1, 1'b0);
    chk("model_pin.m3", m3 == 4, 1'b1);

    // Three full periods of the divided clocks.
    repeat (23) @(posedge clk);
    #2;
    if (out_rise.size() < 2 || out_fall.size() < 1 || b4_rise.size() < 2 ||
        b4_fall.size() < 1 || b3_rise.size() < 2 || b3_fall.size() < 1) begin
      total++;
      bad++;
      $display("FAIL edge_capture: got out_r=%0d b4_r=%0d b4_f=%0d b3_r=%0d want >=2/2/1/2",
               out_rise.size(), b4_rise.size(), b4_fall.size(), b3_rise.size());
    end else begin
      chk_t("out_first_rise", out_rise[0], 55.0);
      chk_t("out_period", out_rise[1] - out_rise[0], 70.0);
      chk_t("out_high", out_fall[0] - out_rise[0], 30.0);
      chk_t("bit4_rise_with_out", b4_rise[0], out_rise[0]);
      chk_t("bit4_high", b4_fall[0] - b4_rise[0], 35.0);
      chk_t("bit4_low", b4_rise[1] - b4_fall[0], 35.0);
      chk_t("bit4_period", b4_rise[1] - b4_rise[0], 70.0);
      chk_t("bit3_width", b3_fall[0] - b3_rise[0], 10.0);
      chk_t("bit3_spacing", b3_rise[1] - b3_rise[0], 70.0);
    end

    // Mid-count reset at count 5, between edges.
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (m0 == 5) found = 1'b1;
    end
    chk("reach_count5", found, 1'b1);
    #2 rst = 1'b0;
    #1 chk_reset_literal("midreset");
    @(negedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1 chk("resume.i0.count1", a_bit1 & ~a_bit2 & ~a_out, 1'b1);
    @(posedge clk);
    #1 chk("resume.i0.count2", ~a_bit1 & a_bit2 & ~a_out, 1'b1);

    // Randomized asynchronous resets at random points in the sequence.
    for (int k = 0; k < 40; k++) begin
      repeat ($urandom_range(1, 20)) @(posedge clk);
      #($urandom_range(2, 3));
      rst = 1'b0;
      #1 chk_reset_literal("rand_reset");
      repeat ($urandom_range(0, 2)) @(posedge clk);
      @(negedge clk);
      #($urandom_range(2, 3));
      rst = 1'b1;
    end
    repeat (30) @(posedge clk);
    #2 chk_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #90000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
